c3lib_cdc_toggle_tx: RTL
========================

C3LIB_CDC_TOGGLE_TX -- requirements
Module: c3lib_cdc_toggle_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: payload width in bits, legal range 1..64.
REQ-002 SHALL have parameter SYNC_STAGES, default 3: ack synchronizer depth, legal range 2..4.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: ack timeout threshold, legal range 2..65535; used only with the timeout feature.
REQ-004 SHALL have port clk, input, 1 bit: single source-domain clock; all flops on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous assert, active-high reset; the block expects deassertion to be synchronous to clk.
REQ-006 SHALL have port src_valid, input, 1 bit: source has a word to send.
REQ-007 SHALL have port src_data, input, WIDTH bits: word to send; sampled only on accept.
REQ-008 SHALL have port src_ready, output, 1 bit: block can accept a word.
REQ-009 SHALL have port ack_toggle, input, 1 bit: asynchronous acknowledge toggle from the destination domain.
REQ-010 SHALL have port req_toggle, output, 1 bit: registered request toggle to the destination domain.
REQ-011 SHALL have port xfer_data, output, WIDTH bits: registered payload to the destination domain.
REQ-012 SHALL have port timeout_err, output, 1 bit: sticky ack-timeout flag.

Function
REQ-013 SHALL implement a two-state FSM with states IDLE and WAIT_ACK.
REQ-014 SHALL drive src_ready = 1 exactly when the state is IDLE, decoded from the state register only.
REQ-015 SHALL perform an accept on any clk edge with src_valid=1 and src_ready=1; on accept: xfer_data <= src_data, req_toggle <= ~req_toggle, state <= WAIT_ACK.
REQ-016 SHALL pass ack_toggle through a SYNC_STAGES flop synchronizer to form ack_sync before any use.
REQ-017 SHALL move from WAIT_ACK to IDLE on the first edge where ack_sync == req_toggle; src_ready rises in the following cycle.
REQ-018 SHALL hold xfer_data and req_toggle stable for all of WAIT_ACK and all of IDLE; they change only on accept.
REQ-019 SHALL ignore src_valid and src_data while in WAIT_ACK; there is no queuing.
REQ-020 SHALL ignore ack_sync changes while in IDLE, with no state or output effect.
REQ-021 SHALL allow back-to-back transfers: an accept is legal in the first IDLE cycle after a return from WAIT_ACK.
REQ-022 SHALL have a minimum accept-to-ready latency of 2 + SYNC_STAGES cycles of clk, plus the destination round trip.

Reset
REQ-023 SHALL reset to: state IDLE, src_ready=1, req_toggle=0, xfer_data=0, synchronizer flops=0, timeout counter=0, timeout_err=0.
REQ-024 SHALL apply reset asserted mid-transfer immediately and asynchronously, abandoning the transfer; the destination side is reset by the same system event.

Configuration
REQ-025 SHALL gate the timeout feature with macro C3LIB_CDC_TX_TIMEOUT_EN.
REQ-026 SHALL, with C3LIB_CDC_TX_TIMEOUT_EN defined, count clk cycles in WAIT_ACK with a 16-bit counter that clears on accept and saturates; timeout_err sets when the count reaches TIMEOUT_CYCLES-1 and stays set until rst.
REQ-027 SHALL keep waiting for ack after a timeout; the handshake is never aborted.
REQ-028 SHALL, without C3LIB_CDC_TX_TIMEOUT_EN, instantiate no counter and tie timeout_err to 0.

Structure
REQ-029 SHALL take the FSM state enum (IDLE, WAIT_ACK) and the default WIDTH, SYNC_STAGES and TIMEOUT_CYCLES constants from shared package c3lib_cdc_pkg.
REQ-030 SHALL instantiate the ack synchronizer as sub-module c3lib_cdc_ack_sync (parameter SYNC_STAGES, active-high async reset to 0), kept don't-touch for hardening.

Verification
REQ-031 SHALL cover single transfer: src_data=0xA5 accepted, ack toggles 4 cycles later -> xfer_data=0xA5, req_toggle 0->1, src_ready low until 3 cycles after the ack edge.
REQ-032 SHALL cover back-to-back: 0x11 then 0x22 with src_valid held high -> two req_toggle edges, xfer_data 0x11 then 0x22, no overlap.
REQ-033 SHALL cover stall: src_data changes 0x33->0x44 during WAIT_ACK -> xfer_data stays 0x33.
REQ-034 SHALL cover spurious ack: ack_toggle toggles while IDLE -> no state, req_toggle or xfer_data change.
REQ-035 SHALL cover timeout: macro defined, TIMEOUT_CYCLES=8, ack withheld -> timeout_err=1 after 8 WAIT_ACK cycles, stays set after a later ack, and the FSM returns to IDLE.
REQ-036 SHALL cover mid-transfer reset: rst pulsed during WAIT_ACK -> outputs return to REQ-023 values asynchronously.

Source files
------------

// File: rtl/c3lib_cdc_pkg.sv
// Shared types and default parameters for the c3lib toggle-handshake CDC blocks.
package c3lib_cdc_pkg;

    localparam int DEF_WIDTH          = 8;
    localparam int DEF_SYNC_STAGES    = 3;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } tx_state_e;

endpackage

// File: rtl/c3lib_cdc_ack_sync.sv
// Multi-flop synchronizer bringing the destination ack toggle into the source clock domain.
module c3lib_cdc_ack_sync
    import c3lib_cdc_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* async_reg = "true" *) logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/c3lib_cdc_toggle_tx.sv
// Source side of a toggle-request / toggle-ack CDC handshake carrying one WIDTH-bit word per transfer.
// Optional sticky ack-timeout flag is built when C3LIB_CDC_TX_TIMEOUT_EN is defined.
module c3lib_cdc_toggle_tx
    import c3lib_cdc_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    input  logic             ack_toggle,
    output logic             req_toggle,
    output logic [WIDTH-1:0] xfer_data,
    output logic             timeout_err
);

    tx_state_e state, state_nxt;
    logic      ack_sync;
    logic      accept;

    (* dont_touch = "true" *)
    c3lib_cdc_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_toggle),
        .q   (ack_sync)
    );

    assign accept = src_valid & src_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Transfer completes once the synchronized ack has caught up with our request toggle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (src_valid)              state_nxt = WAIT_ACK;
            WAIT_ACK: if (ack_sync == req_toggle) state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        src_ready = (state == IDLE);
    end

    // Payload and request toggle only move on accept, so the far side sees them stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_toggle <= 1'b0;
            xfer_data  <= '0;
        end else if (accept) begin
            req_toggle <= ~req_toggle;
            xfer_data  <= src_data;
        end
    end

`ifdef C3LIB_CDC_TX_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;
    logic        to_err;

    // Flag only; the handshake keeps waiting for the ack regardless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else begin
            if (accept)
                to_cnt <= '0;
            else if (state == WAIT_ACK && to_cnt != 16'hFFFF)
                to_cnt <= to_cnt + 16'd1;
            if (state == WAIT_ACK && to_cnt == TO_LAST)
                to_err <= 1'b1;
        end
    end

    assign timeout_err = to_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
